fdiv_sequencer: RTL and testbench

- Wraps the mantissa divide core for binary32 division; sits directly around it as both its feeder and its consumer.
- Accepts two packed binary32 operands over a valid/ready handshake.
- Unpacks the operands, classifies special cases, drives the core's mantissa inputs, and restarts the core with a one-cycle reset pulse.
- Waits the core's fixed iteration latency, then combines the core's m3/decrement_exponent with the computed exponent and sign, and returns a packed result plus exception flags over a valid/ready handshake.

---
 rtl/fdiv_pkg.sv | 26 ++
 rtl/fdiv_special.sv | 59 +++++
 rtl/fdiv_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fdiv_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared constants, FSM state type and operand classification for the binary32 divide sequencer.
package fdiv_pkg;

  localparam int          BIAS           = 127;
  localparam logic [31:0] QNAN           = 32'h7FC0_0000;

  localparam int          FLAG_INVALID   = 3;
  localparam int          FLAG_DIVZERO   = 2;
  localparam int          FLAG_OVERFLOW  = 1;
  localparam int          FLAG_UNDERFLOW = 0;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_PACK, S_HOLD} state_t;

  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fclass_t;

  // A zero exponent classifies as zero whatever the fraction, so subnormals are flushed.
  function automatic fclass_t classify(input logic exp_zero, input logic exp_ones,
                                       input logic frac_zero, input logic frac_msb);
    if (exp_zero)       return CLS_ZERO;
    else if (!exp_ones) return CLS_NORM;
    else if (frac_zero) return CLS_INF;
    else if (frac_msb)  return CLS_QNAN;
    else                return CLS_SNAN;
  endfunction

endpackage

// File: rtl/fdiv_special.sv
// Combinational special-case classifier for a/b: flags NaN, zero and infinity combinations
// and produces the final quotient and exception flags for them.
module fdiv_special
  import fdiv_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int EXP_W = 8
) (
  input  logic [EXP_W+WIDTH:0] i_a,
  input  logic [EXP_W+WIDTH:0] i_b,
  output logic                 o_is_special,
  output logic [EXP_W+WIDTH:0] o_result,
  output logic [3:0]           o_flags
);

  localparam int MSB = EXP_W + WIDTH;
  localparam logic [EXP_W+WIDTH:0] P_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(WIDTH-1){1'b0}}};

  fclass_t                w_ca;
  fclass_t                w_cb;
  logic                   w_sign;
  logic                   w_any_nan;
  logic [EXP_W+WIDTH:0]   w_inf;
  logic [EXP_W+WIDTH:0]   w_zero;

  assign w_ca = classify(i_a[MSB-1:WIDTH] == '0, &i_a[MSB-1:WIDTH],
                         i_a[WIDTH-1:0] == '0, i_a[WIDTH-1]);
  assign w_cb = classify(i_b[MSB-1:WIDTH] == '0, &i_b[MSB-1:WIDTH],
                         i_b[WIDTH-1:0] == '0, i_b[WIDTH-1]);

  assign w_sign    = i_a[MSB] ^ i_b[MSB];
  assign w_any_nan = (w_ca inside {CLS_QNAN, CLS_SNAN}) || (w_cb inside {CLS_QNAN, CLS_SNAN});
  assign w_inf     = {w_sign, {EXP_W{1'b1}}, {WIDTH{1'b0}}};
  assign w_zero    = {w_sign, {(EXP_W+WIDTH){1'b0}}};

  // Branch order is the priority order; a quiet NaN input propagates without raising invalid.
  always_comb begin
    o_is_special = 1'b1;
    o_result     = P_QNAN;
    o_flags      = '0;
    if (w_any_nan) begin
      o_flags[FLAG_INVALID] = (w_ca == CLS_SNAN) || (w_cb == CLS_SNAN);
    end else if ((w_ca == CLS_ZERO && w_cb == CLS_ZERO) ||
                 (w_ca == CLS_INF  && w_cb == CLS_INF)) begin
      o_flags[FLAG_INVALID] = 1'b1;
    end else if (w_cb == CLS_ZERO && w_ca != CLS_INF) begin
      o_result              = w_inf;
      o_flags[FLAG_DIVZERO] = 1'b1;
    end else if (w_ca == CLS_INF) begin
      o_result = w_inf;
    end else if (w_cb == CLS_INF || w_ca == CLS_ZERO) begin
      o_result = w_zero;
    end else begin
      o_is_special = 1'b0;
      o_result     = '0;
    end
  end

endmodule

// File: rtl/fdiv_sequencer.sv
// Binary32 divide sequencer: feeds and restarts the mantissa divide core, then packs its quotient.
// Optional FDIV_STICKY_FLAGS_EN adds accumulated exception flags (sticky_flags / sticky_clear).
module fdiv_sequencer
  import fdiv_pkg::*;
#(
  parameter int WIDTH        = 23,
  parameter int EXP_W        = 8,
  parameter int CORE_LATENCY = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [EXP_W+WIDTH:0] a,
  input  logic [EXP_W+WIDTH:0] b,
  input  logic                 round_mode,
  output logic                 core_reset,
  output logic [1:0]           core_op,
  output logic                 core_round_mode,
  output logic [WIDTH-1:0]     core_m1,
  output logic [WIDTH-1:0]     core_m2,
  input  logic [WIDTH-1:0]     core_m3,
  input  logic                 core_dec_exp,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [EXP_W+WIDTH:0] result,
  output logic [3:0]           flags
`ifdef FDIV_STICKY_FLAGS_EN
  ,
  output logic [3:0]           sticky_flags,
  input  logic                 sticky_clear
`endif
);

  localparam int MSB   = EXP_W + WIDTH;
  localparam int CNT_W = $clog2(CORE_LATENCY + 1);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sign;
  logic [EXP_W-1:0]     r_ea;
  logic [EXP_W-1:0]     r_eb;
  logic [WIDTH-1:0]     r_m1;
  logic [WIDTH-1:0]     r_m2;
  logic                 r_rm;
  logic [MSB:0]         r_result;
  logic [3:0]           r_flags;

  logic                 w_is_special;
  logic [MSB:0]         w_spec_result;
  logic [3:0]           w_spec_flags;
  logic [EXP_W+1:0]     w_e3;
  logic                 w_ovf;
  logic                 w_unf;
  logic [MSB:0]         w_pack_result;
  logic [3:0]           w_pack_flags;

  fdiv_special #(.WIDTH(WIDTH), .EXP_W(EXP_W)) u_special (
    .i_a          (a),
    .i_b          (b),
    .o_is_special (w_is_special),
    .o_result     (w_spec_result),
    .o_flags      (w_spec_flags)
  );

  assign req_ready       = (r_state == S_IDLE);
  assign res_valid       = (r_state == S_HOLD);
  assign core_reset      = reset || (r_state == S_LAUNCH);
  assign core_op         = 2'b00;
  assign core_round_mode = r_rm;
  assign core_m1         = r_m1;
  assign core_m2         = r_m2;
  assign result          = r_result;
  assign flags           = r_flags;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = w_is_special ? S_HOLD : S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (r_cnt == '0) w_next = S_PACK;
      S_PACK:   w_next = S_HOLD;
      S_HOLD:   if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Exponent is evaluated modulo 2^(EXP_W+2); the top bit acts as the sign.
  assign w_e3  = {2'b00, r_ea} - {2'b00, r_eb} + (EXP_W+2)'(BIAS)
               - {{(EXP_W+1){1'b0}}, core_dec_exp};
  assign w_ovf = !w_e3[EXP_W+1] && (w_e3[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
  assign w_unf = w_e3[EXP_W+1] || (w_e3 == '0);

  always_comb begin
    w_pack_result = {r_sign, w_e3[EXP_W-1:0], core_m3};
    w_pack_flags  = '0;
    if (w_ovf) begin
      w_pack_flags[FLAG_OVERFLOW] = 1'b1;
      w_pack_result = r_rm ? {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {WIDTH{1'b1}}}
                           : {r_sign, {EXP_W{1'b1}}, {WIDTH{1'b0}}};
    end else if (w_unf) begin
      w_pack_flags[FLAG_UNDERFLOW] = 1'b1;
      w_pack_result = {r_sign, {(EXP_W+WIDTH){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_rm     <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_sign <= a[MSB] ^ b[MSB];
          r_ea   <= a[MSB-1:WIDTH];
          r_eb   <= b[MSB-1:WIDTH];
          r_m1   <= a[WIDTH-1:0];
          r_m2   <= b[WIDTH-1:0];
          r_rm   <= round_mode;
          if (w_is_special) begin
            r_result <= w_spec_result;
            r_flags  <= w_spec_flags;
          end
        end
        S_LAUNCH: r_cnt <= CNT_W'(CORE_LATENCY - 1);
        S_WAIT:   if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_PACK: begin
          r_result <= w_pack_result;
          r_flags  <= w_pack_flags;
        end
        default: ;
      endcase
    end
  end

`ifdef FDIV_STICKY_FLAGS_EN
  logic [3:0] r_sticky;

  always_ff @(posedge clk) begin
    if (reset || sticky_clear)       r_sticky <= '0;
    else if (res_valid && res_ready) r_sticky <= r_sticky | r_flags;
  end

  assign sticky_flags = r_sticky;
`else
  // Without the sticky option, flags describe only the result currently presented.
`endif

endmodule

// File: tb/tb_fdiv_sequencer.sv
// Directed bench for fdiv_sequencer; the bench plays the mantissa core with per-vector m3/dec values.
module tb_fdiv_sequencer;

  localparam int CORE_LATENCY = 12;
  localparam int NORMAL_LAT   = CORE_LATENCY + 2;
  localparam int NVEC         = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] a;
  logic [31:0] b;
  logic        roundMode;
  logic        coreReset;
  logic [1:0]  coreOp;
  logic        coreRoundMode;
  logic [22:0] coreM1;
  logic [22:0] coreM2;
  logic [22:0] coreM3;
  logic        coreDec;
  logic        resValid;
  logic        resReady;
  logic [31:0] result;
  logic [3:0]  flags;

  int testsRun = 0;
  int failures = 0;
  int launchTotal = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic [22:0] m3;
    logic        dec;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        special;
  } vec_t;

  vec_t vecs [NVEC];

  fdiv_sequencer #(.WIDTH(23), .EXP_W(8), .CORE_LATENCY(CORE_LATENCY)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (reqValid),
    .req_ready       (reqReady),
    .a               (a),
    .b               (b),
    .round_mode      (roundMode),
    .core_reset      (coreReset),
    .core_op         (coreOp),
    .core_round_mode (coreRoundMode),
    .core_m1         (coreM1),
    .core_m2         (coreM2),
    .core_m3         (coreM3),
    .core_dec_exp    (coreDec),
    .res_valid       (resValid),
    .res_ready       (resReady),
    .result          (result),
    .flags           (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && coreReset) launchTotal++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic startOp(input logic [31:0] va, input logic [31:0] vb, input logic rm,
                         input logic [22:0] m3, input logic dec);
    a = va; b = vb; roundMode = rm; coreM3 = m3; coreDec = dec;
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!resValid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finishResult();
    resReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resReady = 1'b0;
    checkOutput("res_valid_after_hs", {31'b0, resValid}, 32'd0);
    checkOutput("req_ready_after_hs", {31'b0, reqReady}, 32'd1);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int lat;
    int launch0;
    launch0 = launchTotal;
    checkOutput($sformatf("v%0d req_ready", idx), {31'b0, reqReady}, 32'd1);
    startOp(v.a, v.b, v.rm, v.m3, v.dec);
    waitResult(lat);
    checkOutput($sformatf("v%0d latency", idx), lat, v.special ? 32'd0 : NORMAL_LAT);
    checkOutput($sformatf("v%0d result", idx), result, v.res);
    checkOutput($sformatf("v%0d flags", idx), {28'b0, flags}, {28'b0, v.flags});
    checkOutput($sformatf("v%0d launches", idx), launchTotal - launch0, v.special ? 32'd0 : 32'd1);
    checkOutput($sformatf("v%0d core_m1", idx), {9'b0, coreM1}, {9'b0, v.a[22:0]});
    checkOutput($sformatf("v%0d core_m2", idx), {9'b0, coreM2}, {9'b0, v.b[22:0]});
    checkOutput($sformatf("v%0d core_rm", idx), {31'b0, coreRoundMode}, {31'b0, v.rm});
    checkOutput($sformatf("v%0d req_ready_hold", idx), {31'b0, reqReady}, 32'd0);
    finishResult();
  endtask

  initial begin
    int lat;
    int sawValid;
    logic [31:0] held;

    //          a             b             rm    m3           dec   result        flags  special
    vecs[0]  = '{32'h40C00000, 32'h40000000, 1'b0, 23'h400000, 1'b0, 32'h40400000, 4'h0, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b0, 23'h2AAAAB, 1'b1, 32'h3EAAAAAB, 4'h0, 1'b0};
    vecs[2]  = '{32'h3F800000, 32'h40400000, 1'b1, 23'h2AAAAA, 1'b1, 32'h3EAAAAAA, 4'h0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 1'b0, 23'h000000, 1'b0, 32'h7F800000, 4'h4, 1'b1};
    vecs[4]  = '{32'h7F000000, 32'h00800000, 1'b0, 23'h000000, 1'b0, 32'h7F800000, 4'h2, 1'b0};
    vecs[5]  = '{32'h7F000000, 32'h00800000, 1'b1, 23'h000000, 1'b0, 32'h7F7FFFFF, 4'h2, 1'b0};
    vecs[6]  = '{32'h00800000, 32'h40000000, 1'b0, 23'h000000, 1'b0, 32'h00000000, 4'h1, 1'b0};
    vecs[7]  = '{32'h7F800001, 32'h3F800000, 1'b0, 23'h000000, 1'b0, 32'h7FC00000, 4'h8, 1'b1};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 23'h000000, 1'b0, 32'h7FC00000, 4'h0, 1'b1};
    vecs[9]  = '{32'h00000000, 32'h80000000, 1'b0, 23'h000000, 1'b0, 32'h7FC00000, 4'h8, 1'b1};
    vecs[10] = '{32'h7F800000, 32'hFF800000, 1'b0, 23'h000000, 1'b0, 32'h7FC00000, 4'h8, 1'b1};
    vecs[11] = '{32'hFF800000, 32'h3F800000, 1'b0, 23'h000000, 1'b0, 32'hFF800000, 4'h0, 1'b1};
    vecs[12] = '{32'hBF800000, 32'h7F800000, 1'b0, 23'h000000, 1'b0, 32'h80000000, 4'h0, 1'b1};
    vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 23'h000000, 1'b0, 32'h00000000, 4'h0, 1'b1};
    vecs[14] = '{32'hC0C00000, 32'h40000000, 1'b0, 23'h400000, 1'b0, 32'hC0400000, 4'h0, 1'b0};
    vecs[15] = '{32'h7F800000, 32'h00000000, 1'b0, 23'h000000, 1'b0, 32'h7F800000, 4'h0, 1'b1};

    reset = 1'b1; reqValid = 1'b0; resReady = 1'b0;
    a = '0; b = '0; roundMode = 1'b0; coreM3 = '0; coreDec = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst core_reset", {31'b0, coreReset}, 32'd1);
    checkOutput("rst req_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("rst res_valid", {31'b0, resValid}, 32'd0);
    checkOutput("rst result", result, 32'd0);
    checkOutput("rst flags", {28'b0, flags}, 32'd0);
    checkOutput("rst core_m1", {9'b0, coreM1}, 32'd0);
    checkOutput("rst core_op", {30'b0, coreOp}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle core_reset", {31'b0, coreReset}, 32'd0);

    for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

    $display("[TB] backpressure: result held with res_ready low");
    startOp(32'h3F800000, 32'h40400000, 1'b0, 23'h2AAAAB, 1'b1);
    waitResult(lat);
    checkOutput("bp latency", lat, NORMAL_LAT);
    held = result;
    coreM3 = 23'h555555;
    coreDec = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("bp result c%0d", i), result, 32'h3EAAAAAB);
      checkOutput($sformatf("bp res_valid c%0d", i), {31'b0, resValid}, 32'd1);
      checkOutput($sformatf("bp req_ready c%0d", i), {31'b0, reqReady}, 32'd0);
    end
    checkOutput("bp first sample", held, 32'h3EAAAAAB);
    finishResult();

    $display("[TB] reset asserted during core wait");
    startOp(32'h7F000000, 32'h00800000, 1'b0, 23'h000000, 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst core_reset", {31'b0, coreReset}, 32'd1);
    checkOutput("midrst res_valid", {31'b0, resValid}, 32'd0);
    checkOutput("midrst req_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("midrst result", result, 32'd0);
    checkOutput("midrst flags", {28'b0, flags}, 32'd0);
    reset = 1'b0;
    sawValid = 0;
    for (int i = 0; i < 2 * NORMAL_LAT; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (resValid) sawValid++;
    end
    checkOutput("midrst no stale result", sawValid, 32'd0);
    checkOutput("midrst idle after", {31'b0, reqReady}, 32'd1);

    applyStimulus(99, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
